sprite_mem_loader: RTL
======================

# sprite_mem_loader

Load controller for the sprite's index image RAM and palette RAM. It accepts a byte stream under a valid/ready handshake and decodes a one-byte command. It then sequences the write ports: 256 palette entries (3 bytes each, packed to 24 bits) or 65536 image index bytes. It sits between the host byte source (UART/DMA bridge) and the write side of the two sprite BRAMs, and can defer writes to vertical blanking so the display read path never sees a torn frame.

## Interface
- IMG_DEPTH, 65536, image RAM entries; image address width is $clog2(IMG_DEPTH).
- PAL_DEPTH, 256, palette RAM entries; palette address width is $clog2(PAL_DEPTH).
- pixel_clk_in  in  1  pixel clock; the block's only clock.
- rst_n_in  in  1  reset; asynchronous assert, active-low.
- data_in  in  8  stream byte.
- valid_in  in  1  data_in is valid.
- ready_out  out  1  loader accepts the byte this cycle.
- abort_in  in  1  synchronous abort: return to IDLE.
- vblank_in  in  1  display is in vertical blanking; used only with VBLANK_GATE_EN.
- img_we_out / img_addr_out / img_data_out  out  1 / 16 / 8  image RAM write port.
- pal_we_out / pal_addr_out / pal_data_out  out  1 / 8 / 24  palette RAM write port; data is {R,G,B}.
- busy_out  out  1  high in every state except IDLE.
- done_out  out  1  one-cycle pulse when a load completes.
- err_out  out  1  one-cycle pulse when an unknown command is received.

## Operation
- A transfer occurs on any cycle with valid_in && ready_out.
- States:
  - IDLE: the accepted byte is a command. 0x01 -> PAL_R. 0x02 -> IMG. Any other value -> err_out pulse, stay in IDLE.
  - PAL_R: latch byte as R -> PAL_G.
  - PAL_G: latch byte as G -> PAL_B.
  - PAL_B: issue a palette write {R,G,B} at pal_idx. If pal_idx == PAL_DEPTH-1, go to IDLE and pulse done_out; otherwise increment pal_idx and go to PAL_R.
  - IMG: issue an image write of the byte at img_idx. If img_idx == IMG_DEPTH-1, go to IDLE and pulse done_out; otherwise increment img_idx.
- Entering PAL_R from IDLE clears pal_idx. Entering IMG from IDLE clears img_idx.
- The counters never wrap silently; the terminal index ends the load.
- Without the gate, ready_out = 1 in every state, so IDLE always accepts a command.
- abort_in has priority over a simultaneous transfer: the byte is dropped, the state goes to IDLE, no done pulse is issued, and already-written RAM contents stay.
- abort_in in IDLE has no effect.
- Reset mid-load behaves the same as abort; RAM contents are untouched.
- Command byte 0x00 is an error like any other unknown value.

## Timing
- All outputs are registered except ready_out.
- Reset values: all outputs 0, state IDLE, counters 0. ready_out follows its combinational rule once reset is released.
- Write latency: the *_we_out strobe, address and data appear one cycle after the accepting edge. We is high for exactly one cycle per write.
- done_out asserts in the same cycle as the final write strobe.
- err_out asserts one cycle after the bad command byte is accepted.
- Full throughput is one byte per cycle:
  - palette load: 1 + 768 bytes;
  - image load: 1 + 65536 bytes.
- Address and data outputs hold their last value while the strobe is low.

## Configuration
- VBLANK_GATE_EN defined:
  - in PAL_* and IMG states, ready_out = vblank_in; in IDLE, ready_out = 1;
  - each write therefore lands in blanking, at most one cycle after vblank_in was sampled high;
  - a load may span several frames;
  - the source must hold valid_in and data_in stable while ready_out is low.
- VBLANK_GATE_EN undefined: vblank_in is ignored and ready_out = 1 always.

## Structure
- Shared package sprite_pkg holds:
  - state enum: IDLE, PAL_R, PAL_G, PAL_B, IMG;
  - command constants: CMD_PAL = 8'h01, CMD_IMG = 8'h02;
  - default IMG_DEPTH and PAL_DEPTH.
- No sub-module is needed. The RGB byte packing is three registers inside the FSM; splitting it out would only add ports.

## Test plan
- Palette load: send 0x01 followed by 768 bytes, pattern R=i, G=i^0xFF, B=0x55. Expect 256 pal_we_out strobes with addr i and data {i, ~i, 0x55}, and done_out together with addr 255.
- Image load with backpressure: send 0x02 followed by 65536 bytes of value addr[7:0], with valid_in toggled randomly. Expect exactly 65536 strobes, addresses 0..65535 in order, done_out once, and busy_out low afterwards.
- Bad command: send 0x07 in IDLE. Expect an err_out pulse, no writes, and the next byte 0x01 starts a palette load.
- Abort: assert abort_in with a transfer after 10 image bytes. Expect 10 writes, the 11th byte dropped, no done_out, state IDLE; the next 0x02 load restarts at address 0.
- Async reset: drop rst_n_in mid-PAL_G, off the clock edge. Expect all outputs at 0 immediately; after release, the palette load restarts at index 0.
- VBLANK_GATE_EN defined: hold vblank_in low during an image load. Expect ready_out low and no strobes; raise vblank_in for 5 cycles with valid_in held high and expect exactly 5 writes.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite RAM load controller:
// FSM state encoding, command bytes and default RAM depths.
package sprite_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PAL_R = 3'd1,
    PAL_G = 3'd2,
    PAL_B = 3'd3,
    IMG   = 3'd4
  } state_t;

  localparam logic [7:0] CMD_PAL = 8'h01;
  localparam logic [7:0] CMD_IMG = 8'h02;

  localparam int DEFAULT_IMG_DEPTH = 65536;
  localparam int DEFAULT_PAL_DEPTH = 256;

endpackage

// File: rtl/sprite_mem_loader_if.sv
// Byte-stream input, RAM write ports and status of the sprite loader.
// Handshake: a byte moves on every clock edge where valid_in && ready_out;
// the source holds data_in/valid_in stable while ready_out is low.
interface sprite_mem_loader_if
  import sprite_pkg::*;
#(
    parameter int IMG_AW = $clog2(DEFAULT_IMG_DEPTH),
    parameter int PAL_AW = $clog2(DEFAULT_PAL_DEPTH)
);

    logic [7:0]        data_in;
    logic              valid_in;
    logic              ready_out;
    logic              abort_in;
    logic              vblank_in;

    logic              img_we_out;
    logic [IMG_AW-1:0] img_addr_out;
    logic [7:0]        img_data_out;

    logic              pal_we_out;
    logic [PAL_AW-1:0] pal_addr_out;
    logic [23:0]       pal_data_out;

    logic              busy_out;
    logic              done_out;
    logic              err_out;
    state_t            state_dbg;

    // Host side: byte source plus observer of the write ports.
    modport master (
        output data_in, valid_in, abort_in, vblank_in,
        input  ready_out,
        input  img_we_out, img_addr_out, img_data_out,
        input  pal_we_out, pal_addr_out, pal_data_out,
        input  busy_out, done_out, err_out, state_dbg
    );

    // Loader side.
    modport slave (
        input  data_in, valid_in, abort_in, vblank_in,
        output ready_out,
        output img_we_out, img_addr_out, img_data_out,
        output pal_we_out, pal_addr_out, pal_data_out,
        output busy_out, done_out, err_out, state_dbg
    );

endinterface

// File: rtl/sprite_mem_loader.sv
// Sprite image/palette RAM load controller: decodes a command byte, then streams
// bytes into the palette or image write port. Optional macro: VBLANK_GATE_EN.
module sprite_mem_loader
  import sprite_pkg::*;
#(
    parameter int IMG_DEPTH = DEFAULT_IMG_DEPTH,
    parameter int PAL_DEPTH = DEFAULT_PAL_DEPTH
) (
    input  logic               pixel_clk_in,
    input  logic               rst_n_in,
    sprite_mem_loader_if.slave bus
);

    localparam int IMG_AW = $clog2(IMG_DEPTH);
    localparam int PAL_AW = $clog2(PAL_DEPTH);
    localparam logic [IMG_AW-1:0] IMG_LAST = IMG_AW'(IMG_DEPTH - 1);
    localparam logic [PAL_AW-1:0] PAL_LAST = PAL_AW'(PAL_DEPTH - 1);

    state_t            state;
    logic [7:0]        r_q;
    logic [7:0]        g_q;
    logic [PAL_AW-1:0] pal_idx;
    logic [IMG_AW-1:0] img_idx;

    logic              img_we_q;
    logic [IMG_AW-1:0] img_addr_q;
    logic [7:0]        img_data_q;
    logic              pal_we_q;
    logic [PAL_AW-1:0] pal_addr_q;
    logic [23:0]       pal_data_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              ready;
    logic              xfer;
    logic              abort_load;

`ifdef VBLANK_GATE_EN
    // Data bytes are only taken during blanking so every RAM write lands there.
    assign ready = (state == IDLE) ? 1'b1 : bus.vblank_in;
`else
    logic unused_vblank;
    assign unused_vblank = bus.vblank_in;
    assign ready         = 1'b1;
`endif

    assign xfer       = bus.valid_in && ready;
    assign abort_load = bus.abort_in && (state != IDLE);

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            r_q        <= '0;
            g_q        <= '0;
            pal_idx    <= '0;
            img_idx    <= '0;
            img_we_q   <= 1'b0;
            img_addr_q <= '0;
            img_data_q <= '0;
            pal_we_q   <= 1'b0;
            pal_addr_q <= '0;
            pal_data_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            img_we_q <= 1'b0;
            pal_we_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            if (abort_load) begin
                // The byte on this edge is dropped; RAM keeps what was written.
                state  <= IDLE;
                busy_q <= 1'b0;
            end else if (xfer) begin
                case (state)
                    IDLE: begin
                        if (bus.data_in == CMD_PAL) begin
                            state   <= PAL_R;
                            pal_idx <= '0;
                            busy_q  <= 1'b1;
                        end else if (bus.data_in == CMD_IMG) begin
                            state   <= IMG;
                            img_idx <= '0;
                            busy_q  <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                    PAL_R: begin
                        r_q   <= bus.data_in;
                        state <= PAL_G;
                    end
                    PAL_G: begin
                        g_q   <= bus.data_in;
                        state <= PAL_B;
                    end
                    PAL_B: begin
                        pal_we_q   <= 1'b1;
                        pal_addr_q <= pal_idx;
                        pal_data_q <= {r_q, g_q, bus.data_in};
                        if (pal_idx == PAL_LAST) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            pal_idx <= pal_idx + PAL_AW'(1);
                            state   <= PAL_R;
                        end
                    end
                    IMG: begin
                        img_we_q   <= 1'b1;
                        img_addr_q <= img_idx;
                        img_data_q <= bus.data_in;
                        if (img_idx == IMG_LAST) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            img_idx <= img_idx + IMG_AW'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ready_out    = ready;
    assign bus.img_we_out   = img_we_q;
    assign bus.img_addr_out = img_addr_q;
    assign bus.img_data_out = img_data_q;
    assign bus.pal_we_out   = pal_we_q;
    assign bus.pal_addr_out = pal_addr_q;
    assign bus.pal_data_out = pal_data_q;
    assign bus.busy_out     = busy_q;
    assign bus.done_out     = done_q;
    assign bus.err_out      = err_q;
    assign bus.state_dbg    = state;

endmodule
